// File: rtl/fixed_multiplier_seq_pkg.sv
// Shared types and constant helpers for the iterative fixed-point multiplier.
// MUL_ACCUM_EN (optional) adds the accumulate mode in the interface and top.
package fixed_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic longint sat_max(input int unsigned width, input bit is_signed);
        return is_signed ? (longint'(1) << (width - 1)) - longint'(1)
                         : (longint'(1) << width) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned width, input bit is_signed);
        return is_signed ? -(longint'(1) << (width - 1)) : longint'(0);
    endfunction

    function automatic int unsigned iter_count(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/fixed_multiplier_seq_if.sv
// Trigger/ready/done handshake and result bus of the fixed-point multiplier.
// MUL_ACCUM_EN adds the acc_en request bit.
interface fixed_multiplier_seq_if #(
    parameter int unsigned C_WIDTH = 16
);
    logic               trigger;
    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic               round_en;
`ifdef MUL_ACCUM_EN
    logic               acc_en;
`endif
    logic               ready;
    logic               done;
    logic [C_WIDTH-1:0] y;
    logic               overflow;

`ifdef MUL_ACCUM_EN
    modport master (output trigger, a, b, round_en, acc_en,
                    input  ready, done, y, overflow);
    modport slave  (input  trigger, a, b, round_en, acc_en,
                    output ready, done, y, overflow);
`else
    modport master (output trigger, a, b, round_en,
                    input  ready, done, y, overflow);
    modport slave  (input  trigger, a, b, round_en,
                    output ready, done, y, overflow);
`endif

endinterface

// File: rtl/fixed_multiplier_seq_round_sat.sv
// Combinational round / shift / sign / (accumulate) / saturate stage for FINAL.
module fixed_round_sat
    import fixed_mul_pkg::*;
#(
    parameter int unsigned C_WIDTH     = 16,
    parameter int unsigned FIXED_POINT = 8,
    parameter int unsigned SIGNED      = 1,
    parameter int unsigned PW          = 2 * C_WIDTH + 2
) (
    input  logic [PW-1:0]      prod,
    input  logic               sign,
    input  logic               round_en,
    input  logic               acc_en,
    input  logic [C_WIDTH-1:0] y_prev,
    output logic [C_WIDTH-1:0] y_c,
    output logic               ovf_c
);
    localparam int unsigned RW       = PW + 1;
    localparam int unsigned SW       = RW + 2;
    localparam int unsigned HALF_SH  = (FIXED_POINT > 0) ? FIXED_POINT - 1 : 0;
    localparam logic [RW-1:0] HALF   = (FIXED_POINT > 0) ? (RW'(1) << HALF_SH) : RW'(0);
    localparam logic signed [SW-1:0] MAXV = SW'(sat_max(C_WIDTH, SIGNED != 0));
    localparam logic signed [SW-1:0] MINV = SW'(sat_min(C_WIDTH, SIGNED != 0));
    localparam logic [C_WIDTH-1:0]   MAX_Y = C_WIDTH'(sat_max(C_WIDTH, SIGNED != 0));
    localparam logic [C_WIDTH-1:0]   MIN_Y = C_WIDTH'(sat_min(C_WIDTH, SIGNED != 0));

    logic [RW-1:0]        rounded;
    logic [RW-1:0]        shifted;
    logic signed [SW-1:0] mag_s;
    logic signed [SW-1:0] prev_s;
    logic signed [SW-1:0] val;

    // Rounding is applied to the magnitude so halves round away from zero.
    always_comb begin
        rounded = RW'(prod) + (round_en ? HALF : RW'(0));
        shifted = rounded >> FIXED_POINT;
        mag_s   = $signed({2'b00, shifted});
        val     = sign ? -mag_s : mag_s;
        if (SIGNED != 0) prev_s = SW'($signed(y_prev));
        else             prev_s = $signed(SW'(y_prev));
        if (acc_en) val = val + prev_s;

        y_c   = val[C_WIDTH-1:0];
        ovf_c = 1'b0;
        if (val > MAXV) begin
            y_c   = MAX_Y;
            ovf_c = 1'b1;
        end else if (val < MINV) begin
            y_c   = MIN_Y;
            ovf_c = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_multiplier_seq.sv
// Iterative shift-add fixed-point multiplier with rounding and saturation.
// Defining MUL_ACCUM_EN enables accumulate mode (y = sat(y_prev + product)).
module fixed_multiplier_seq
    import fixed_mul_pkg::*;
#(
    parameter int unsigned C_WIDTH        = 16,
    parameter int unsigned FIXED_POINT    = 8,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned SIGNED         = 1
) (
    input  logic                 ctl_clk,
    input  logic                 reset,
    fixed_multiplier_seq_if.slave bus
);
    localparam int unsigned MW  = C_WIDTH + 1;
    localparam int unsigned PW  = 2 * C_WIDTH + 2;
    localparam int unsigned BPC = BITS_PER_CYCLE;
    localparam int unsigned N   = iter_count(C_WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    logic [PW-1:0]      ma_sh;
    logic [MW-1:0]      mb_sh;
    logic [PW-1:0]      prod;
    logic [CW-1:0]      cnt;
    logic               sign_q;
    logic               rnd_q;
    logic               acc_q;
    logic               ready_q;
    logic               done_q;
    logic [C_WIDTH-1:0] y_q;
    logic               ovf_q;

    logic               neg_a_c;
    logic               neg_b_c;
    logic [MW-1:0]      a_mag_c;
    logic [MW-1:0]      b_mag_c;
    logic [PW-1:0]      partial_c;
    logic [PW-1:0]      extra_c;
    logic               last_c;
    logic [C_WIDTH-1:0] y_c;
    logic               ovf_c;

    // Magnitudes carry one extra bit so the most-negative operand stays exact.
    always_comb begin
        neg_a_c   = (SIGNED != 0) && bus.a[C_WIDTH-1];
        neg_b_c   = (SIGNED != 0) && bus.b[C_WIDTH-1];
        a_mag_c   = neg_a_c ? MW'(0) - {bus.a[C_WIDTH-1], bus.a} : {1'b0, bus.a};
        b_mag_c   = neg_b_c ? MW'(0) - {bus.b[C_WIDTH-1], bus.b} : {1'b0, bus.b};
        last_c    = (cnt == CW'(N - 1));
        partial_c = ma_sh * PW'(mb_sh[BPC-1:0]);
        extra_c   = ((SIGNED != 0) && last_c && mb_sh[BPC]) ? (ma_sh << BPC) : PW'(0);
    end

    fixed_round_sat #(
        .C_WIDTH     (C_WIDTH),
        .FIXED_POINT (FIXED_POINT),
        .SIGNED      (SIGNED),
        .PW          (PW)
    ) u_round_sat (
        .prod     (prod),
        .sign     (sign_q),
        .round_en (rnd_q),
        .acc_en   (acc_q),
        .y_prev   (y_q),
        .y_c      (y_c),
        .ovf_c    (ovf_c)
    );

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state   <= IDLE;
            ma_sh   <= '0;
            mb_sh   <= '0;
            prod    <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            rnd_q   <= 1'b0;
            acc_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.trigger) begin
                        ma_sh   <= PW'(a_mag_c);
                        mb_sh   <= b_mag_c;
                        prod    <= '0;
                        cnt     <= '0;
                        sign_q  <= neg_a_c ^ neg_b_c;
                        rnd_q   <= bus.round_en;
`ifdef MUL_ACCUM_EN
                        acc_q   <= bus.acc_en;
`else
                        acc_q   <= 1'b0;
`endif
                        ready_q <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    prod  <= prod + partial_c + extra_c;
                    ma_sh <= ma_sh << BPC;
                    mb_sh <= mb_sh >> BPC;
                    cnt   <= cnt + CW'(1);
                    if (last_c) state <= FINAL;
                end
                FINAL: begin
                    y_q    <= y_c;
                    ovf_q  <= ovf_c;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.y        = y_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_fixed_multiplier_seq.sv
// Directed bench: signed 8b/Q4 BPC=1 instance plus unsigned 8b/Q4 BPC=4 instance.
module tb_fixed_multiplier_seq;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
`ifdef MUL_ACCUM_EN
    logic acc_drv = 1'b0;
`endif

    always #5 clk = ~clk;

    fixed_multiplier_seq_if #(.C_WIDTH(8)) bus_s ();
    fixed_multiplier_seq_if #(.C_WIDTH(8)) bus_u ();

    fixed_multiplier_seq #(
        .C_WIDTH(8), .FIXED_POINT(4), .BITS_PER_CYCLE(1), .SIGNED(1)
    ) u_s (.ctl_clk(clk), .reset(reset), .bus(bus_s));

    fixed_multiplier_seq #(
        .C_WIDTH(8), .FIXED_POINT(4), .BITS_PER_CYCLE(4), .SIGNED(0)
    ) u_u (.ctl_clk(clk), .reset(reset), .bus(bus_u));

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       rnd;
        logic [7:0] y;
        logic       ovf;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic trig, input logic [7:0] a,
                         input logic [7:0] b, input logic rnd);
        if (sel == 0) begin
            bus_s.trigger = trig; bus_s.a = a; bus_s.b = b; bus_s.round_en = rnd;
        end else begin
            bus_u.trigger = trig; bus_u.a = a; bus_u.b = b; bus_u.round_en = rnd;
        end
`ifdef MUL_ACCUM_EN
        bus_s.acc_en = acc_drv;
        bus_u.acc_en = acc_drv;
`endif
    endtask

    task automatic sample(input int sel, output logic rdy, output logic dn,
                          output logic [7:0] y, output logic ovf);
        if (sel == 0) begin
            rdy = bus_s.ready; dn = bus_s.done; y = bus_s.y; ovf = bus_s.overflow;
        end else begin
            rdy = bus_u.ready; dn = bus_u.done; y = bus_u.y; ovf = bus_u.overflow;
        end
    endtask

    // One operation: trigger for one edge, then count cycles until done.
    task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic rnd, output logic [7:0] y, output logic ovf,
                      output int lat);
        logic rdy, dn, o;
        logic [7:0] yy;
        @(negedge clk);
        drive(sel, 1'b1, a, b, rnd);
        @(posedge clk);
        #1 drive(sel, 1'b0, a, b, rnd);
        lat = -1; y = 8'h00; ovf = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            sample(sel, rdy, dn, yy, o);
            if (dn) begin
                lat = c; y = yy; ovf = o;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       v[12];
        logic [7:0] y;
        logic       ovf, rdy, dn;
        int         lat, ndone, d1, d2;
        logic [7:0] yfirst;

        v[0]  = '{0, 8'h38, 8'h20, 1'b0, 8'h70, 1'b0, 10};
        v[1]  = '{0, 8'h24, 8'h70, 1'b0, 8'h7F, 1'b1, 10};
        v[2]  = '{0, 8'h80, 8'hF0, 1'b0, 8'h7F, 1'b1, 10};
        v[3]  = '{0, 8'h80, 8'h10, 1'b0, 8'h80, 1'b0, 10};
        v[4]  = '{0, 8'hE8, 8'h20, 1'b0, 8'hD0, 1'b0, 10};
        v[5]  = '{0, 8'h01, 8'h08, 1'b0, 8'h00, 1'b0, 10};
        v[6]  = '{0, 8'h01, 8'h08, 1'b1, 8'h01, 1'b0, 10};
        v[7]  = '{0, 8'hFF, 8'h08, 1'b1, 8'hFF, 1'b0, 10};
        v[8]  = '{0, 8'hFF, 8'h08, 1'b0, 8'h00, 1'b0, 10};
        v[9]  = '{0, 8'h80, 8'h80, 1'b0, 8'h7F, 1'b1, 10};
        v[10] = '{1, 8'hFF, 8'h10, 1'b0, 8'hFF, 1'b0, 4};
        v[11] = '{1, 8'hFF, 8'h20, 1'b0, 8'hFF, 1'b1, 4};

        reset = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sample(0, rdy, dn, y, ovf);
        chk("reset_ready", 32'(rdy), 32'd1);
        chk("reset_done", 32'(dn), 32'd0);
        chk("reset_y", 32'(y), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 12; i++) begin
            op(v[i].sel, v[i].a, v[i].b, v[i].rnd, y, ovf, lat);
            chk($sformatf("v%0d_y", i), 32'(y), 32'(v[i].y));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(v[i].ovf));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
        end

        // ready comes back the cycle after done
        op(0, 8'h38, 8'h20, 1'b0, y, ovf, lat);
        @(negedge clk);
        sample(0, rdy, dn, y, ovf);
        chk("ready_after_done", 32'(rdy), 32'd1);
        chk("done_one_cycle", 32'(dn), 32'd0);

        // trigger during CALC with new operands is ignored
        @(negedge clk);
        drive(0, 1'b1, 8'h38, 8'h20, 1'b0);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h38, 8'h20, 1'b0);
        ndone = 0; d1 = -1; yfirst = 8'h00;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            sample(0, rdy, dn, y, ovf);
            if (dn) begin
                ndone++;
                if (d1 < 0) begin d1 = c; yfirst = y; end
            end
            if (c == 3) drive(0, 1'b1, 8'h10, 8'h10, 1'b1);
            else if (c == 4) drive(0, 1'b0, 8'h10, 8'h10, 1'b1);
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_lat", 32'(d1), 32'd10);
        chk("ign_y", 32'(yfirst), 32'h70);

        // reset in the middle of CALC discards the operation
        @(negedge clk);
        drive(0, 1'b1, 8'h24, 8'h70, 1'b0);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h24, 8'h70, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sample(0, rdy, dn, y, ovf);
        chk("mid_rst_ready", 32'(rdy), 32'd1);
        chk("mid_rst_y", 32'(y), 32'h0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        ndone = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            sample(0, rdy, dn, y, ovf);
            if (dn) ndone++;
        end
        chk("mid_rst_nodone", 32'(ndone), 32'd0);
        op(0, 8'h38, 8'h20, 1'b0, y, ovf, lat);
        chk("post_rst_y", 32'(y), 32'h70);
        chk("post_rst_lat", 32'(lat), 32'd10);

        // trigger held high restarts as soon as ready returns
        @(negedge clk);
        drive(0, 1'b1, 8'h38, 8'h20, 1'b0);
        ndone = 0; d1 = -1; d2 = -1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            sample(0, rdy, dn, y, ovf);
            if (dn) begin
                ndone++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (c == 21) drive(0, 1'b0, 8'h38, 8'h20, 1'b0);
        end
        chk("held_ndone", 32'(ndone), 32'd2);
        chk("held_d1", 32'(d1), 32'd10);
        chk("held_d2", 32'(d2), 32'd21);
        repeat (2) @(negedge clk);

`ifdef MUL_ACCUM_EN
        acc_drv = 1'b0;
        op(0, 8'h38, 8'h20, 1'b0, y, ovf, lat);
        chk("acc_base_y", 32'(y), 32'h70);
        acc_drv = 1'b1;
        op(0, 8'h10, 8'h10, 1'b0, y, ovf, lat);
        chk("acc_sat_y", 32'(y), 32'h7F);
        chk("acc_sat_ovf", 32'(ovf), 32'd1);
        acc_drv = 1'b0;
        op(0, 8'h10, 8'h10, 1'b0, y, ovf, lat);
        chk("acc_plain_y", 32'(y), 32'h10);
        acc_drv = 1'b1;
        op(0, 8'h10, 8'h10, 1'b0, y, ovf, lat);
        chk("acc_sum_y", 32'(y), 32'h20);
        chk("acc_sum_ovf", 32'(ovf), 32'd0);
        acc_drv = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
